// File: rtl/pnr_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module   : pnr_bus_initiator
// Brief    : Single-outstanding bus initiator. Each command becomes one or more
//            strobed bus beats; reads with len > 1 drain a FIFO at one address.
//            Define PNR_BUS_INIT_TIMEOUT_EN to build the WAIT-state timeout.
// Revision : 1.0 - initial release
// ============================================================================
module pnr_bus_initiator #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    input  logic [15:0] cmd_len_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        rsp_last_o,
    output logic [31:0] sys_addr_o,
    output logic [31:0] sys_wdata_o,
    output logic        sys_wen_o,
    output logic        sys_ren_o,
    input  logic [31:0] sys_rdata_i,
    input  logic        sys_err_i,
    input  logic        sys_ack_i,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STROBE = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [15:0] r_len;
    logic [15:0] r_beat;
    logic        r_cmd_ready;
    logic        r_wen;
    logic        r_ren;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic        r_rsp_last;

    logic        w_final_beat;
    logic        w_timeout;

    // Beats are counted from 0, so the last one is len-1 (len is never 0 here).
    assign w_final_beat = (r_beat == (r_len - 16'd1));

`ifdef PNR_BUS_INIT_TIMEOUT_EN
    logic [15:0] r_wait_cnt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wait_cnt <= '0;
        end else if (r_state != S_WAIT) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
        end
    end

    // Fires during the TIMEOUT-th WAIT cycle when no ack has arrived.
    assign w_timeout = (r_wait_cnt == 16'(TIMEOUT - 1));
`else
    localparam int c_unused_timeout = TIMEOUT;
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state     <= S_IDLE;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_len       <= '0;
            r_beat      <= '0;
            r_cmd_ready <= 1'b0;
            r_wen       <= 1'b0;
            r_ren       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!r_cmd_ready) begin
                        r_cmd_ready <= 1'b1;
                    end else if (cmd_valid_i) begin
                        r_cmd_ready <= 1'b0;
                        r_write     <= cmd_write_i;
                        r_addr      <= cmd_addr_i;
                        r_wdata     <= cmd_wdata_i;
                        r_len       <= (cmd_write_i || (cmd_len_i == 16'd0)) ? 16'd1 : cmd_len_i;
                        r_beat      <= '0;
                        r_wen       <= cmd_write_i;
                        r_ren       <= ~cmd_write_i;
                        r_state     <= S_STROBE;
                    end
                end
                S_STROBE: begin
                    r_wen   <= 1'b0;
                    r_ren   <= 1'b0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (sys_ack_i) begin
                        r_rsp_rdata <= r_write ? 32'd0 : sys_rdata_i;
                        r_rsp_err   <= sys_err_i;
                        r_rsp_last  <= w_final_beat | sys_err_i;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (w_timeout) begin
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_last  <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        if (r_rsp_last) begin
                            r_cmd_ready <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            // Next FIFO beat re-strobes the same address.
                            r_beat  <= r_beat + 16'd1;
                            r_wen   <= r_write;
                            r_ren   <= ~r_write;
                            r_state <= S_STROBE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o = r_cmd_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;
    assign rsp_last_o  = r_rsp_last;
    assign sys_addr_o  = r_addr;
    assign sys_wdata_o = r_wdata;
    assign sys_wen_o   = r_wen;
    assign sys_ren_o   = r_ren;
    assign busy_o      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pnr_bus_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pnr_bus_initiator
// Brief    : Self-checking bench: bus responder, transaction-level model and
//            directed scenarios for pnr_bus_initiator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pnr_bus_initiator;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
    logic [31:0] cmd_addr_i, cmd_wdata_i;
    logic [15:0] cmd_len_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_last_o;
    logic [31:0] rsp_rdata_o;
    logic [31:0] sys_addr_o, sys_wdata_o, sys_rdata_i;
    logic        sys_wen_o, sys_ren_o, sys_err_i, sys_ack_i, busy_o;

    always #5 clk_i = ~clk_i;

    pnr_bus_initiator #(.TIMEOUT(8)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_len_i(cmd_len_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .rsp_last_o(rsp_last_o),
        .sys_addr_o(sys_addr_o), .sys_wdata_o(sys_wdata_o), .sys_wen_o(sys_wen_o),
        .sys_ren_o(sys_ren_o), .sys_rdata_i(sys_rdata_i), .sys_err_i(sys_err_i),
        .sys_ack_i(sys_ack_i), .busy_o(busy_o)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          beats;
    } cmd_t;
    typedef struct {
        logic [31:0] data;
        logic        err;
    } bus_t;

    cmd_t cmd_q[$];
    bus_t bus_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Responder knobs
    int          ack_dly    = 1;
    bit          no_ack     = 1'b0;
    bit          spur       = 1'b0;
    int          err_at     = -1;
    int          strobe_cnt = 0;
    logic [31:0] fifo_val   = 32'd1;
    int          rdy_mode   = 0;

    // Model state
    int          n_ren = 0, n_wen = 0;
    int          beat_i = 0, strobes_this = 0, since_strb = 99;
    bit          ready_ok = 1'b0, prev_strb = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0;
    logic [31:0] prev_rdata;
    logic        prev_err, prev_last;
    bus_t        mb;
    logic [31:0] m_data;
    logic        m_err, m_last;
    int          m_beats;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event occurred or bound expired, required otherwise", nm);
    endtask

    // Bus responder: acks ack_dly cycles after each strobe, FIFO at 0x70.
    initial begin
        logic [31:0] bd;
        logic        be;
        sys_ack_i = 1'b0; sys_err_i = 1'b0; sys_rdata_i = 32'd0;
        forever begin
            @(posedge clk_i); #1;
            if (rstn_i && (sys_ren_o || sys_wen_o)) begin
                if (sys_wen_o)                bd = 32'hFFFF_0000 | 32'(strobe_cnt);
                else if (sys_addr_o == 32'h70) begin bd = fifo_val; fifo_val = fifo_val + 32'd1; end
                else if (sys_addr_o == 32'h74) bd = 32'h0000_0010;
                else                           bd = sys_addr_o ^ 32'h5A5A_0000;
                be = (strobe_cnt == err_at);
                strobe_cnt++;
                if (!no_ack) begin
                    if (spur) begin
                        sys_ack_i = 1'b1; sys_rdata_i = 32'hDEAD_BEEF; sys_err_i = 1'b1;
                    end
                    repeat (ack_dly) @(posedge clk_i);
                    #1;
                    sys_ack_i = 1'b1; sys_rdata_i = bd; sys_err_i = be;
                    bus_q.push_back('{bd, be});
                    @(posedge clk_i); #1;
                    sys_ack_i = 1'b0; sys_err_i = 1'b0; sys_rdata_i = 32'h0BAD_0BAD;
                end
            end
        end
    end

    initial begin
        rsp_ready_i = 1'b1;
        forever begin
            @(posedge clk_i); #1;
            case (rdy_mode)
                0:       rsp_ready_i = 1'b1;
                1:       rsp_ready_i = ~rsp_ready_i;
                default: rsp_ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Compare process: every cycle, DUT against the transaction-level model.
    always @(negedge clk_i) begin
        if (!rstn_i) begin
            cmd_q.delete(); bus_q.delete();
            beat_i = 0; strobes_this = 0; since_strb = 99;
            ready_ok = 1'b0; prev_strb = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0;
        end else begin
            check1("busy", busy_o, cmd_q.size() != 0);
            check1("cmd_ready", cmd_ready_o, ready_ok && (cmd_q.size() == 0));
            ready_ok = 1'b1;
            check1("strobe_onehot", sys_wen_o & sys_ren_o, 1'b0);
            since_strb++;
            if (sys_wen_o || sys_ren_o) begin
                if (sys_ren_o) n_ren++; else n_wen++;
                strobes_this++;
                check1("strobe_width", prev_strb, 1'b0);
                check1("strobe_spacing", since_strb >= 3, 1'b1);
                since_strb = 0;
                if (cmd_q.size() == 0) fail("strobe_without_cmd");
                else begin
                    check1("strobe_kind", sys_wen_o, cmd_q[0].write);
                    check32("strobe_addr", sys_addr_o, cmd_q[0].addr);
                    if (sys_wen_o) check32("strobe_wdata", sys_wdata_o, cmd_q[0].wdata);
                end
            end
            if (sys_ack_i && cmd_q.size() != 0) check32("ack_addr", sys_addr_o, cmd_q[0].addr);
            if (rsp_valid_o) begin
                if (prev_valid && !prev_ready) begin
                    check32("rsp_hold_rdata", rsp_rdata_o, prev_rdata);
                    check1("rsp_hold_err", rsp_err_o, prev_err);
                    check1("rsp_hold_last", rsp_last_o, prev_last);
                end
                if (cmd_q.size() == 0) fail("rsp_without_cmd");
                else if (rsp_ready_i) begin
                    m_data = 32'd0; m_err = 1'b1;
                    if (bus_q.size() != 0) begin
                        mb     = bus_q.pop_front();
                        m_data = cmd_q[0].write ? 32'd0 : mb.data;
                        m_err  = mb.err;
                    end else begin
`ifndef PNR_BUS_INIT_TIMEOUT_EN
                        fail("rsp_without_ack");
`endif
                    end
                    m_last = ((beat_i + 1) == cmd_q[0].beats) || m_err;
                    check32("rsp_rdata", rsp_rdata_o, m_data);
                    check1("rsp_err", rsp_err_o, m_err);
                    check1("rsp_last", rsp_last_o, m_last);
                    check32("strobes_per_beat", 32'(strobes_this), 32'(beat_i + 1));
                    if (m_last) begin
                        void'(cmd_q.pop_front());
                        beat_i = 0; strobes_this = 0;
                    end else begin
                        beat_i++;
                    end
                end
            end else if (prev_valid && !prev_ready) begin
                fail("rsp_valid_dropped");
            end
            prev_strb  = sys_wen_o | sys_ren_o;
            prev_valid = rsp_valid_o; prev_ready = rsp_ready_i;
            prev_rdata = rsp_rdata_o; prev_err = rsp_err_o; prev_last = rsp_last_o;
            if (cmd_valid_i && cmd_ready_o) begin
                m_beats = (cmd_write_i || cmd_len_i == 16'd0) ? 1 : int'(cmd_len_i);
                cmd_q.push_back('{cmd_write_i, cmd_addr_i, cmd_wdata_i, m_beats});
            end
        end
    end

    task automatic do_cmd(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [15:0] ln);
        int k = 0;
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = a; cmd_wdata_i = wd; cmd_len_i = ln;
        do begin @(negedge clk_i); k++; end while (!cmd_ready_o && k < 500);
        if (!cmd_ready_o) fail("cmd_accept_bound");
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_len_i = 16'($urandom);
        cmd_addr_i = $urandom; cmd_wdata_i = $urandom;
    endtask

    task automatic wait_rsp(input string nm, input logic [31:0] ed, input logic ee, input logic el);
        int k = 0;
        while (!(rsp_valid_o && rsp_ready_i) && k < 300) begin @(negedge clk_i); k++; end
        if (!(rsp_valid_o && rsp_ready_i)) fail({nm, "_bound"});
        else begin
            check32({nm, "_rdata"}, rsp_rdata_o, ed);
            check1({nm, "_err"}, rsp_err_o, ee);
            check1({nm, "_last"}, rsp_last_o, el);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        do begin @(negedge clk_i); k++; end while (busy_o && k < 2000);
        if (busy_o) fail("idle_bound");
    endtask

    initial begin
        int k;
        int r0, w0;
        rstn_i = 1'b0; cmd_valid_i = 1'b0; cmd_write_i = 1'b0;
        cmd_addr_i = '0; cmd_wdata_i = '0; cmd_len_i = '0;
        repeat (2) @(negedge clk_i);
        check1("rst_cmd_ready", cmd_ready_o, 1'b0);
        check1("rst_busy", busy_o, 1'b0);
        check1("rst_rsp_valid", rsp_valid_o, 1'b0);
        check1("rst_ren", sys_ren_o, 1'b0);
        check1("rst_wen", sys_wen_o, 1'b0);
        check32("rst_rdata", rsp_rdata_o, 32'd0);
        check32("rst_addr", sys_addr_o, 32'd0);
        check1("rst_err_last", rsp_err_o | rsp_last_o, 1'b0);
        @(posedge clk_i); #1 rstn_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check1("ready_after_reset", cmd_ready_o, 1'b1);

        // Single write, ack one cycle after the strobe
        w0 = n_wen;
        do_cmd(1'b1, 32'h24, 32'hA5A5_0001, 16'd0);
        k = 0;
        do begin @(negedge clk_i); k++; end while (!rsp_valid_o && k < 50);
        check32("wr_latency", 32'(k), 32'd3);
        wait_rsp("wr", 32'd0, 1'b0, 1'b1);
        @(negedge clk_i);
        check1("wr_busy_after", busy_o, 1'b0);
        check32("wr_pulses", 32'(n_wen - w0), 32'd1);

        // Single read
        r0 = n_ren;
        do_cmd(1'b0, 32'h74, 32'd0, 16'd1);
        wait_rsp("rd74", 32'h10, 1'b0, 1'b1);
        wait_idle();
        check32("rd74_pulses", 32'(n_ren - r0), 32'd1);

        // Four-beat FIFO drain with toggling ready
        rdy_mode = 1; fifo_val = 32'd1; r0 = n_ren;
        do_cmd(1'b0, 32'h70, 32'd0, 16'd4);
        wait_rsp("burst_b1", 32'd1, 1'b0, 1'b0);
        wait_rsp("burst_b2", 32'd2, 1'b0, 1'b0);
        wait_rsp("burst_b3", 32'd3, 1'b0, 1'b0);
        wait_rsp("burst_b4", 32'd4, 1'b0, 1'b1);
        wait_idle();
        check32("burst_pulses", 32'(n_ren - r0), 32'd4);
        rdy_mode = 0;

        // Error on beat 2 of 3 terminates the burst
        fifo_val = 32'd1; r0 = n_ren; err_at = strobe_cnt + 1;
        do_cmd(1'b0, 32'h70, 32'd0, 16'd3);
        wait_rsp("err_b1", 32'd1, 1'b0, 1'b0);
        wait_rsp("err_b2", 32'd2, 1'b1, 1'b1);
        wait_idle();
        repeat (6) @(negedge clk_i);
        check32("err_pulses", 32'(n_ren - r0), 32'd2);
        err_at = -1;

        // len=0 means one beat
        do_cmd(1'b0, 32'h10, 32'd0, 16'd0);
        wait_rsp("len0", 32'h5A5A_0010, 1'b0, 1'b1);
        wait_idle();

        // Ack asserted during the strobe cycle must be ignored
        spur = 1'b1;
        do_cmd(1'b0, 32'h74, 32'd0, 16'd1);
        wait_rsp("spur", 32'h10, 1'b0, 1'b1);
        wait_idle();
        spur = 1'b0;

        // Command offered while busy stays pending and is not lost
        rdy_mode = 2; ack_dly = 3; r0 = n_ren; w0 = n_wen;
        do_cmd(1'b1, 32'h40, 32'h1234_5678, 16'd7);
        do_cmd(1'b0, 32'h70, 32'd0, 16'd2);
        wait_idle();
        check32("pend_wen", 32'(n_wen - w0), 32'd1);
        check32("pend_ren", 32'(n_ren - r0), 32'd2);
        rdy_mode = 0; ack_dly = 1;

`ifdef PNR_BUS_INIT_TIMEOUT_EN
        no_ack = 1'b1; sys_rdata_i = 32'hCAFE_F00D;
        do_cmd(1'b0, 32'h30, 32'd0, 16'd1);
        k = 0;
        do begin @(negedge clk_i); k++; end while (!rsp_valid_o && k < 100);
        check32("to_latency", 32'(k), 32'd10);
        wait_rsp("timeout", 32'd0, 1'b1, 1'b1);
        wait_idle();
        no_ack = 1'b0;
`endif

        // Reset during the strobe cycle
        no_ack = 1'b1;
        do_cmd(1'b0, 32'h08, 32'd0, 16'd1);
        @(negedge clk_i);
        check1("strobe_before_rst", sys_ren_o, 1'b1);
        #2 rstn_i = 1'b0; #1;
        check1("rst_strobe_drop", sys_ren_o, 1'b0);
        repeat (2) @(posedge clk_i); #1 rstn_i = 1'b1;

        // Reset during WAIT of a 5-beat burst
        do_cmd(1'b0, 32'h70, 32'd0, 16'd5);
        repeat (3) @(negedge clk_i);
        check1("mid_busy", busy_o, 1'b1);
        #2 rstn_i = 1'b0; #1;
        check1("mid_rst_ren", sys_ren_o, 1'b0);
        check1("mid_rst_wen", sys_wen_o, 1'b0);
        check1("mid_rst_valid", rsp_valid_o, 1'b0);
        check1("mid_rst_busy", busy_o, 1'b0);
        check1("mid_rst_ready", cmd_ready_o, 1'b0);
        repeat (2) @(posedge clk_i); #1 rstn_i = 1'b1;
        no_ack = 1'b0;
        do_cmd(1'b0, 32'h04, 32'd0, 16'd0);
        wait_rsp("post_rst_rd", 32'h5A5A_0004, 1'b0, 1'b1);
        wait_idle();
        repeat (4) @(negedge clk_i);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time bound expired, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
